// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: default widths, special encodings, fetch FSM states, IF/ID layout.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package cpu_pkg;

  localparam int PC_WIDTH          = 19;
  localparam int INSTRUCTION_WIDTH = 32;
  localparam int MEMORY_SIZE       = 1024;
  localparam int RESET_PC          = 0;

  localparam logic [INSTRUCTION_WIDTH-1:0] HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [INSTRUCTION_WIDTH-1:0] NOP_INSTR  = 32'h0000_0000;

  // RUN fetches; HALTED freezes the PC until a redirect arrives.
  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  // IF/ID pipeline register contents at the default widths; decode consumes these fields.
  typedef struct packed {
    logic [INSTRUCTION_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]          pc;
    logic [PC_WIDTH-1:0]          pc_next;
    logic                         valid;
  } ifid_t;

  // Address range test done at 64 bits so any PC width compares cleanly against the memory size.
  function automatic logic addr_in_range(input logic [63:0] addr, input int unsigned size);
    return addr < 64'(size);
  endfunction

endpackage

// File: rtl/ifid_register.sv
// IF/ID pipeline register: captures a fetched instruction with its address and link value.
// Latency: 1 cycle from load to outputs.
// Backpressure: neither load nor bubble asserted holds the current contents (stall).
module ifid_register #(
  parameter int                           PC_WIDTH          = cpu_pkg::PC_WIDTH,
  parameter int                           INSTRUCTION_WIDTH = cpu_pkg::INSTRUCTION_WIDTH,
  parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INSTR         = cpu_pkg::NOP_INSTR
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load,
  input  logic                         bubble,
  input  logic [INSTRUCTION_WIDTH-1:0] instr_d,
  input  logic [PC_WIDTH-1:0]          pc_d,
  input  logic [PC_WIDTH-1:0]          pc_next_d,
  output logic [INSTRUCTION_WIDTH-1:0] instr_q,
  output logic [PC_WIDTH-1:0]          pc_q,
  output logic [PC_WIDTH-1:0]          pc_next_q,
  output logic                         valid_q
);
  import cpu_pkg::*;

  // Same layout as cpu_pkg::ifid_t, sized by this instance's parameters.
  typedef struct packed {
    logic [INSTRUCTION_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]          pc;
    logic [PC_WIDTH-1:0]          pc_next;
    logic                         valid;
  } entry_t;

  localparam entry_t BUBBLE = '{
    instr:   NOP_INSTR,
    pc:      '0,
    pc_next: '0,
    valid:   1'b0
  };

  entry_t entry_q;
  entry_t entry_d;

  // Next contents: bubble beats load; with neither, the register holds.
  always_comb begin
    entry_d = entry_q;
    if (bubble) begin
      entry_d = BUBBLE;
    end else if (load) begin
      entry_d.instr   = instr_d;
      entry_d.pc      = pc_d;
      entry_d.pc_next = pc_next_d;
      entry_d.valid   = 1'b1;
    end
  end

  // Pipeline register with asynchronous clear to a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= BUBBLE;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign instr_q   = entry_q.instr;
  assign pc_q      = entry_q.pc;
  assign pc_next_q = entry_q.pc_next;
  assign valid_q   = entry_q.valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, addresses instruction memory, fills IF/ID, detects HALT.
// Latency: instruction at pc_o appears on ifid_* one cycle later.
// Backpressure: stall_i holds PC and IF/ID; redirect_i overrides stall and flush.
module fetch_stage #(
  parameter int                           PC_WIDTH          = cpu_pkg::PC_WIDTH,
  parameter int                           INSTRUCTION_WIDTH = cpu_pkg::INSTRUCTION_WIDTH,
  parameter int                           MEMORY_SIZE       = cpu_pkg::MEMORY_SIZE,
  parameter logic [PC_WIDTH-1:0]          RESET_PC          = PC_WIDTH'(cpu_pkg::RESET_PC),
  parameter logic [INSTRUCTION_WIDTH-1:0] HALT_INSTR        = cpu_pkg::HALT_INSTR,
  parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INSTR         = cpu_pkg::NOP_INSTR
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall_i,
  input  logic                         flush_i,
  input  logic                         redirect_i,
  input  logic [PC_WIDTH-1:0]          redirect_pc_i,
  input  logic [INSTRUCTION_WIDTH-1:0] instr_i,
  output logic [PC_WIDTH-1:0]          pc_o,
  output logic [INSTRUCTION_WIDTH-1:0] ifid_instr_o,
  output logic [PC_WIDTH-1:0]          ifid_pc_o,
  output logic [PC_WIDTH-1:0]          ifid_pc_next_o,
  output logic                         ifid_valid_o,
  output logic                         fetch_fault_o,
  output logic                         halted_o
);
  import cpu_pkg::*;

  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

  fetch_state_t        state_q;
  fetch_state_t        state_d;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;
  logic [PC_WIDTH-1:0] pc_inc;
  logic                fault_q;
  logic                fault_set;
  logic                ifid_load;
  logic                ifid_bubble;
  logic                in_range;
  logic                is_halt;

  // Sequential successor wraps naturally at 2^PC_WIDTH.
  assign pc_inc   = pc_q + PC_ONE;
  assign in_range = addr_in_range(64'(pc_q), MEMORY_SIZE);
  assign is_halt  = (instr_i == HALT_INSTR);

  // Per-edge decision: redirect, then halted/stall hold, then flush, then normal fetch.
  always_comb begin
    pc_d        = pc_q;
    state_d     = state_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    fault_set   = 1'b0;
    if (redirect_i) begin
      // Taken branch/jump: squash what was fetched and leave HALTED if halt was on the wrong path.
      pc_d        = redirect_pc_i;
      ifid_bubble = 1'b1;
      state_d     = RUN;
    end else if (state_q == HALTED) begin
      // PC frozen; IF/ID drains to bubbles unless decode is stalled on it.
      ifid_bubble = !stall_i;
    end else if (stall_i) begin
      // Hold everything; a pending flush is re-presented once the stall drops.
      pc_d = pc_q;
    end else if (flush_i) begin
      pc_d        = pc_inc;
      ifid_bubble = 1'b1;
    end else begin
      pc_d = pc_inc;
      if (!in_range) begin
        // Memory returns nothing meaningful here: insert a bubble and latch the fault.
        ifid_bubble = 1'b1;
        fault_set   = 1'b1;
      end else begin
        ifid_load = 1'b1;
        if (is_halt) begin
          state_d = HALTED;
        end
      end
    end
  end

  // PC, FSM state and sticky fault flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      state_q <= RUN;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      fault_q <= fault_q | fault_set;
    end
  end

  ifid_register #(
    .PC_WIDTH          (PC_WIDTH),
    .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH),
    .NOP_INSTR         (NOP_INSTR)
  ) u_ifid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ifid_load),
    .bubble    (ifid_bubble),
    .instr_d   (instr_i),
    .pc_d      (pc_q),
    .pc_next_d (pc_inc),
    .instr_q   (ifid_instr_o),
    .pc_q      (ifid_pc_o),
    .pc_next_q (ifid_pc_next_o),
    .valid_q   (ifid_valid_o)
  );

  assign pc_o          = pc_q;
  assign fetch_fault_o = fault_q;
  assign halted_o      = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: default 19-bit PC instance plus a 10-bit PC instance for wrap.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: stall, flush and redirect driven directly from the scenario tasks.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect = 1'b0;
  logic [18:0] redirect_pc = '0;
  logic        halt_en = 1'b0;

  logic [18:0] pc_a, ipc_a, inext_a;
  logic [31:0] instr_in_a, instr_a;
  logic        vld_a, fault_a, halt_a;

  logic [9:0]  pc_b, ipc_b, inext_b;
  logic [31:0] instr_in_b, instr_b;
  logic        vld_b, fault_b, halt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory model: word w holds A500_0000 | w; word 7 holds HALT when halt_en is set.
  function automatic logic [31:0] memw(input logic [31:0] a, input logic he);
    if (he && a == 32'd7) return 32'hFFFF_FFFF;
    return 32'hA500_0000 | a;
  endfunction

  assign instr_in_a = memw(32'(pc_a), halt_en);
  assign instr_in_b = memw(32'(pc_b), halt_en);

  fetch_stage dut_a (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .instr_i(instr_in_a),
    .pc_o(pc_a), .ifid_instr_o(instr_a), .ifid_pc_o(ipc_a), .ifid_pc_next_o(inext_a),
    .ifid_valid_o(vld_a), .fetch_fault_o(fault_a), .halted_o(halt_a)
  );

  fetch_stage #(.PC_WIDTH(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc[9:0]), .instr_i(instr_in_b),
    .pc_o(pc_b), .ifid_instr_o(instr_b), .ifid_pc_o(ipc_b), .ifid_pc_next_o(inext_b),
    .ifid_valid_o(vld_b), .fetch_fault_o(fault_b), .halted_o(halt_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [92:0] got, exp;
    #12;
    got = {pc_a, instr_a, ipc_a, inext_a, vld_a, fault_a, halt_a, pc_b[0], vld_b};
    exp = {19'd0, 32'h0, 19'd0, 19'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_state: got %h want %h", got, exp); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (vld_a !== 1'b0 || pc_a !== 19'd0) begin
      errors++; $display("FAIL first_cycle_invalid: vld %b pc %0d want 0 0", vld_a, pc_a);
    end
  endtask

  task automatic test_sequential();
    logic [89:0] got, exp;
    for (int i = 0; i < 4; i++) begin
      step();
      got = {pc_a, instr_a, ipc_a, inext_a, vld_a};
      exp = {19'(i + 1), memw(32'(i), 1'b0), 19'(i), 19'(i + 1), 1'b1};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL seq_%0d: got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_stall();
    logic [89:0] got, exp;
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      got = {pc_a, instr_a, ipc_a, inext_a, vld_a};
      exp = {19'd5, 32'hA500_0004, 19'd4, 19'd5, 1'b1};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL stall_hold_%0d: got %h want %h", i, got, exp); end
    end
    stall = 1'b0;
    step();
    got = {pc_a, instr_a, ipc_a, inext_a, vld_a};
    exp = {19'd6, 32'hA500_0005, 19'd5, 19'd6, 1'b1};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL stall_release: got %h want %h", got, exp); end
  endtask

  task automatic test_redirect_priority();
    logic [89:0] got, exp;
    stall = 1'b1; flush = 1'b1; redirect = 1'b1; redirect_pc = 19'h40;
    step();
    stall = 1'b0; flush = 1'b0; redirect = 1'b0;
    got = {pc_a, instr_a, ipc_a, inext_a, vld_a};
    exp = {19'h40, 32'h0, 19'd0, 19'd0, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL redirect_bubble: got %h want %h", got, exp); end
    step();
    got = {pc_a, instr_a, ipc_a, inext_a, vld_a};
    exp = {19'h41, 32'hA500_0040, 19'h40, 19'h41, 1'b1};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL redirect_target: got %h want %h", got, exp); end
  endtask

  task automatic test_flush();
    logic [89:0] got, exp;
    flush = 1'b1;
    step();
    flush = 1'b0;
    got = {pc_a, instr_a, ipc_a, inext_a, vld_a};
    exp = {19'h42, 32'h0, 19'd0, 19'd0, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL flush_bubble: got %h want %h", got, exp); end
  endtask

  task automatic test_halt();
    logic [90:0] got, exp;
    halt_en = 1'b1;
    redirect = 1'b1; redirect_pc = 19'd5;
    step();
    redirect = 1'b0;
    step();
    step();
    step();
    got = {pc_a, instr_a, ipc_a, inext_a, vld_a, halt_a};
    exp = {19'd8, 32'hFFFF_FFFF, 19'd7, 19'd8, 1'b1, 1'b1};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL halt_loaded: got %h want %h", got, exp); end
    for (int i = 0; i < 10; i++) begin
      flush = (i >= 5);
      step();
      got = {pc_a, instr_a, ipc_a, inext_a, vld_a, halt_a};
      exp = {19'd8, 32'h0, 19'd0, 19'd0, 1'b0, 1'b1};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL halted_frozen_%0d: got %h want %h", i, got, exp); end
    end
    flush = 1'b0;
    checks++;
    if (pc_b !== 10'd8 || halt_b !== 1'b1) begin
      errors++; $display("FAIL halted_narrow: pc %0d halted %b want 8 1", pc_b, halt_b);
    end
    redirect = 1'b1; redirect_pc = 19'd2;
    step();
    redirect = 1'b0;
    halt_en = 1'b0;
    got = {pc_a, instr_a, ipc_a, inext_a, vld_a, halt_a};
    exp = {19'd2, 32'h0, 19'd0, 19'd0, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL halt_redirect: got %h want %h", got, exp); end
    step();
    got = {pc_a, instr_a, ipc_a, inext_a, vld_a, halt_a};
    exp = {19'd3, 32'hA500_0002, 19'd2, 19'd3, 1'b1, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL halt_resume: got %h want %h", got, exp); end
  endtask

  task automatic test_out_of_range();
    logic [90:0] got, exp;
    logic [63:0] gb, eb;
    redirect = 1'b1; redirect_pc = 19'd1023;
    step();
    redirect = 1'b0;
    checks++;
    if (pc_a !== 19'd1023 || pc_b !== 10'd1023) begin
      errors++; $display("FAIL oor_redirect: pc_a %0d pc_b %0d want 1023 1023", pc_a, pc_b);
    end
    step();
    got = {pc_a, instr_a, ipc_a, inext_a, vld_a, fault_a};
    exp = {19'd1024, 32'hA500_03FF, 19'd1023, 19'd1024, 1'b1, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL oor_last_word: got %h want %h", got, exp); end
    gb = {pc_b, instr_b, ipc_b, inext_b, vld_b, fault_b};
    eb = {10'd0, 32'hA500_03FF, 10'd1023, 10'd0, 1'b1, 1'b0};
    checks++;
    if (gb !== eb) begin errors++; $display("FAIL wrap_last_word: got %h want %h", gb, eb); end
    step();
    got = {pc_a, instr_a, ipc_a, inext_a, vld_a, fault_a};
    exp = {19'd1025, 32'h0, 19'd0, 19'd0, 1'b0, 1'b1};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL oor_fault: got %h want %h", got, exp); end
    gb = {pc_b, instr_b, ipc_b, inext_b, vld_b, fault_b};
    eb = {10'd1, 32'hA500_0000, 10'd0, 10'd1, 1'b1, 1'b0};
    checks++;
    if (gb !== eb) begin errors++; $display("FAIL wrap_no_fault: got %h want %h", gb, eb); end
    step();
    checks++;
    if (fault_a !== 1'b1) begin errors++; $display("FAIL fault_sticky: got %b want 1", fault_a); end
  endtask

  task automatic test_async_reset();
    logic [92:0] got, exp;
    #3;
    rst_n = 1'b0;
    #1;
    got = {pc_a, instr_a, ipc_a, inext_a, vld_a, fault_a, halt_a, pc_b[0], vld_b};
    exp = {19'd0, 32'h0, 19'd0, 19'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL async_reset: got %h want %h", got, exp); end
    #2;
    rst_n = 1'b1;
    step();
    got = {pc_a, instr_a, ipc_a, inext_a, vld_a, fault_a, halt_a, 2'b00};
    exp = {19'd1, 32'hA500_0000, 19'd0, 19'd1, 1'b1, 1'b0, 1'b0, 2'b00};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL restart: got %h want %h", got, exp); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_priority();
    test_flush();
    test_halt();
    test_out_of_range();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Front end of the vector CPU pipeline. Owns the program counter, drives the word address into the combinational instruction memory, and captures the returned instruction into the IF/ID pipeline register.
- Handles stall, flush and branch/jump redirect from downstream hazard and execute logic.
- Detects the HALT encoding and stops fetch. The decode stage consumes the IF/ID outputs directly.

Parameters:
- PC_WIDTH, 19, width of PC and word address into instruction memory.
- INSTRUCTION_WIDTH, 32, instruction word width.
- MEMORY_SIZE, 1024, number of instruction words; addresses >= MEMORY_SIZE are out of range.
- RESET_PC, 0, PC value loaded on reset.
- HALT_INSTR, 32'hFFFF_FFFF, encoding that stops fetch.
- NOP_INSTR, 32'h0000_0000, bubble encoding placed in IF/ID.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall_i  in  1  hold PC and IF/ID contents (hazard unit)
- flush_i  in  1  replace IF/ID with bubble next edge
- redirect_i  in  1  taken branch/jump from EX
- redirect_pc_i  in  PC_WIDTH  target word address
- instr_i  in  INSTRUCTION_WIDTH  instruction from memory for pc_o (same cycle)
- pc_o  out  PC_WIDTH  current fetch address to instruction memory
- ifid_instr_o  out  INSTRUCTION_WIDTH  registered instruction
- ifid_pc_o  out  PC_WIDTH  address of ifid_instr_o
- ifid_pc_next_o  out  PC_WIDTH  ifid_pc_o + 1 (link value)
- ifid_valid_o  out  1  IF/ID holds a real instruction
- fetch_fault_o  out  1  sticky: fetch attempted at out-of-range address
- halted_o  out  1  FSM in HALTED

Behaviour:
- Reset (async assert, sync-released use): pc_o = RESET_PC; ifid_instr_o = NOP_INSTR; ifid_pc_o = 0; ifid_pc_next_o = 0; ifid_valid_o = 0; fetch_fault_o = 0; halted_o = 0; FSM = RUN. Reset mid-operation discards all state immediately.
- Addressing: word addressed; sequential next PC = pc_o + 1, wrapping modulo 2^PC_WIDTH.
- Latency: instruction at pc_o appears on ifid_* one cycle later.
- FSM has states RUN and HALTED.
- Per-edge priority in RUN:
  1. redirect_i: pc_o <= redirect_pc_i; IF/ID <= bubble (valid 0, NOP). Redirect overrides stall and flush.
  2. stall_i: pc_o and all ifid_* hold. Also applies if flush_i is asserted without redirect; flush is not lost, since the hazard unit holds flush_i until stall drops.
  3. flush_i: pc_o <= pc_o + 1; IF/ID <= bubble.
  4. Normal: pc_o <= pc_o + 1; IF/ID <= {instr_i, pc_o, pc_o + 1, valid 1}.
- Out of range (pc_o >= MEMORY_SIZE) in case 4: IF/ID <= bubble, fetch_fault_o <= 1 (sticky until reset), pc_o still advances.
- HALT detect (case 4 with instr_i == HALT_INSTR):
  - Halt is loaded into IF/ID with valid 1.
  - pc_o <= pc_o + 1; FSM -> HALTED.
- HALTED:
  - pc_o frozen.
  - IF/ID <= bubble each edge unless stall_i, in which case it holds.
  - halted_o = 1.
  - redirect_i (wrong-path halt) applies redirect as above and returns to RUN.
  - flush_i alone does not leave HALTED.
- Simultaneous redirect + HALT fetch: redirect wins; FSM stays RUN.
- Redirect to an out-of-range target is accepted; the fault is flagged when that address is fetched.
- No X propagation: all registers have reset values.

Decomposition:
- Shared package cpu_pkg: PC_WIDTH, INSTRUCTION_WIDTH, HALT_INSTR, NOP_INSTR, enum fetch_state_t {RUN, HALTED}, and struct ifid_t {instr, pc, pc_next, valid}.
- One sub-module, ifid_register: holds ifid_t with load/hold/bubble controls.
- PC logic and FSM live in fetch_stage.
- Instruction memory is instantiated by the parent, not inside this block.

Test Plan:
- Reset then 4 edges with memory words 0..3 = A,B,C,D:
  - pc_o steps 0,1,2,3,4.
  - ifid_instr_o A,B,C,D with ifid_pc_o 0..3 and valid 1.
  - First cycle after reset has valid 0.
- Stall at pc_o = 5 for 3 cycles: pc_o stays 5 and IF/ID holds the instruction from 4. After release, pc_o goes to 6 and IF/ID takes word 5.
- Redirect to 0x40 while stall_i = 1 and flush_i = 1: next edge pc_o = 0x40 and IF/ID is valid 0 with NOP. Following edge IF/ID = word 0x40.
- HALT at word 7: IF/ID = HALT with valid 1, then halted_o = 1 and pc_o frozen at 8 for 10 cycles with IF/ID bubbles. Redirect to 2 resumes at word 2 with halted_o = 0.
- Redirect to 1023 with MEMORY_SIZE = 1024:
  - Word 1023 is fetched.
  - At pc_o = 1024: fetch_fault_o = 1 and bubble.
  - With PC_WIDTH = 10, pc_o wraps to 0 instead and no fault.
- Assert rst_n low mid-stream between clock edges: all outputs immediately reach reset values. Restart fetches from RESET_PC.
